// File: rtl/riscv_pkg.sv
// Shared constants and state encoding for the RISC-V front end.
// The fetch unit imports this package for its reset PC, bubble instruction and FSM states.
package riscv_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } fetch_state_e;

    // Instruction fetches are word aligned, so the low two bits of a target are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: request a word, hold it until decode retires it, then advance the PC.
// The next PC is either PC+4 or a word-aligned ALU target; a misaligned target raises a one-cycle flag.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSel,
    input  logic [31:0] alu_out,
    input  logic        stall_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic         misalign_q;

    logic [31:0]  pc_seq;
    logic [31:0]  pc_d;
    logic         retire;
    logic         misalign_d;

    always_comb begin
        pc_seq     = pc_q + 32'd4;
        retire     = (state_q == S_VALID) && !stall_in;
        pc_d       = PCSel ? align_word(alu_out) : pc_seq;
        misalign_d = retire && PCSel && (alu_out[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        inst_q  <= imem_rdata;
                        state_q <= S_VALID;
                    end
                end
                S_VALID: begin
                    // Memory responses arriving here are stray and deliberately ignored.
                    if (!stall_in) begin
                        pc_q    <= pc_d;
                        inst_q  <= NOP_INST;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // The request is masked while reset is held so nothing is issued before release.
    assign imem_req     = (state_q == S_FETCH) && !rst;
    assign imem_addr    = pc_q;
    assign inst_valid   = (state_q == S_VALID);
    assign inst         = inst_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_seq;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the fetch/retire behaviour.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCSel;
    logic [31:0] alu_out;
    logic        stall_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: whether a fetched word is held, the current PC, the held word, and the error flag.
    bit          m_have;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_mis;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .PCSel        (PCSel),
        .alu_out      (alu_out),
        .stall_in     (stall_in),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0;
        m_pc   = 32'h0;
        m_inst = NOP;
        m_mis  = 0;
    endtask

    // One clock edge of the reference behaviour, from the inputs presented during the cycle.
    task automatic model_step(input bit rdy, input logic [31:0] rd, input bit st,
                              input bit ps, input logic [31:0] alu);
        m_mis = 0;
        if (!m_have) begin
            if (rdy) begin
                m_have = 1;
                m_inst = rd;
            end
        end else if (!st) begin
            if (ps) begin
                m_pc  = alu & 32'hFFFF_FFFC;
                m_mis = (alu % 4) != 0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_inst = NOP;
            m_have = 0;
        end
    endtask

    task automatic check_outputs();
        check("imem_req", {31'b0, imem_req}, {31'b0, !m_have});
        if (!m_have) check("imem_addr", imem_addr, m_pc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
        check("inst", inst, m_inst);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    endtask

    // Entered just after a rising edge; drives, checks mid-cycle, then crosses the next edge.
    task automatic cycle(input bit rdy, input logic [31:0] rd, input bit st,
                         input bit ps, input logic [31:0] alu);
        imem_ready = rdy;
        imem_rdata = rd;
        stall_in   = st;
        PCSel      = ps;
        alu_out    = alu;
        #3;
        check_outputs();
        @(posedge clk);
        model_step(rdy, rd, st, ps, alu);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        PCSel      = 1'b0;
        alu_out    = 32'h0;
        stall_in   = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_mis", {31'b0, misalign_err}, 32'h0);
        rst = 1'b0;

        // First fetch straight out of reset.
        cycle(1, 32'h0050_0093, 0, 0, 32'h0);
        check("first_inst", inst, 32'h0050_0093);
        check("first_valid", {31'b0, inst_valid}, 32'h1);
        check("first_pc", pc, 32'h0);
        check("first_pc4", pc_plus4, 32'h4);

        // Sequential retirement: 0 -> 4 -> 8 -> C.
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("seq_addr4", imem_addr, 32'h4);
        cycle(1, $urandom, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("seq_addr8", imem_addr, 32'h8);
        cycle(1, $urandom, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("seq_addrC", imem_addr, 32'hC);
        cycle(1, $urandom, 0, 0, 32'h0);

        // Branch back to 8, then aligned and misaligned branches taken from pc=8.
        cycle(0, 32'h0, 0, 1, 32'h8);
        cycle(1, $urandom, 0, 0, 32'h0);
        check("br_pc8", pc, 32'h8);
        cycle(0, 32'h0, 0, 1, 32'h0000_0100);
        check("br_addr", imem_addr, 32'h100);
        check("br_nomis", {31'b0, misalign_err}, 32'h0);
        cycle(1, $urandom, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 1, 32'h8);
        cycle(1, $urandom, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 1, 32'h0000_0102);
        check("mis_addr", imem_addr, 32'h100);
        check("mis_pulse", {31'b0, misalign_err}, 32'h1);

        // Memory not ready for three cycles: request held steady.
        for (int i = 0; i < 3; i++) begin
            cycle(0, $urandom, $urandom_range(0, 1), 1, $urandom);
            check("wait_req", {31'b0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'h100);
            check("mis_clear", {31'b0, misalign_err}, 32'h0);
        end
        cycle(1, 32'hDEAD_BEEF, 0, 0, 32'h0);

        // Decode stalls for five cycles: instruction and PC frozen, no new request.
        for (int i = 0; i < 5; i++) begin
            cycle($urandom_range(0, 1), $urandom, 1, 1, $urandom);
            check("stall_inst", inst, 32'hDEAD_BEEF);
            check("stall_pc", pc, 32'h100);
            check("stall_req", {31'b0, imem_req}, 32'h0);
        end

        // PC wraps from FFFF_FFFC to zero.
        cycle(0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        cycle(1, $urandom, 0, 0, 32'h0);
        check("wrap_pc4", pc_plus4, 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 3) == 0, $urandom);
        end

        // Reset asserted mid-fetch at pc=0x40 while memory answers in the same cycle.
        while (!m_have) cycle(1, $urandom, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 1, 32'h40);
        check("pre_rst_addr", imem_addr, 32'h40);
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_inst", inst, NOP);
        check("arst_valid", {31'b0, inst_valid}, 32'h0);
        check("arst_req", {31'b0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        check("late_rdy_valid", {31'b0, inst_valid}, 32'h0);
        check("late_rdy_inst", inst, NOP);
        rst = 1'b0;
        model_reset();
        cycle(1, 32'h1234_5678, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("refetch_next", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter: NOP_INST, 32'h0000_0013, inst value presented while no fetched instruction is held.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: PCSel  input  1  from Control_Unit: 1 = take alu_out as next PC, 0 = take PC+4.
REQ-006 SHALL have port: alu_out  input  32  branch/jump target from datapath ALU.
REQ-007 SHALL have port: stall_in  input  1  datapath not ready to retire current instruction.
REQ-008 SHALL have port: imem_req  output  1  instruction memory read request.
REQ-009 SHALL have port: imem_addr  output  32  instruction memory read address.
REQ-010 SHALL have port: imem_ready  input  1  memory returns data this cycle.
REQ-011 SHALL have port: imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-012 SHALL have port: inst  output  32  instruction to Control_Unit / decode.
REQ-013 SHALL have port: inst_valid  output  1  inst and pc describe a live instruction.
REQ-014 SHALL have port: pc  output  32  address of inst.
REQ-015 SHALL have port: pc_plus4  output  32  pc + 4, for WBSel link path.
REQ-016 SHALL have port: misalign_err  output  1  one-cycle pulse, taken target had alu_out[1:0] != 0.

Function
REQ-017 SHALL implement FSM with states FETCH and VALID only.
REQ-018 FETCH: imem_req=1, imem_addr=pc, inst_valid=0; on imem_ready=1 SHALL register imem_rdata into inst and go to VALID at that edge.
REQ-019 FETCH with imem_ready=0: SHALL stay in FETCH, holding imem_req and imem_addr stable.
REQ-020 VALID: imem_req=0, inst_valid=1; inst and pc SHALL remain stable.
REQ-021 VALID with stall_in=0: at edge SHALL load pc with next_pc, set inst to NOP_INST, go to FETCH.
REQ-022 VALID with stall_in=1: SHALL remain in VALID with pc, inst unchanged; PCSel/alu_out ignored.
REQ-023 next_pc SHALL be {alu_out[31:2],2'b00} when PCSel=1, else pc+4 modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-024 PCSel=1 with alu_out[1:0]!=0 on a retiring VALID cycle: SHALL assert misalign_err for exactly the following cycle; otherwise misalign_err=0.
REQ-025 PCSel and alu_out SHALL be sampled only in VALID with stall_in=0.
REQ-026 pc_plus4 SHALL be combinational pc + 4 at all times.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles (imem_ready=1 in first FETCH cycle); each extra imem_ready=0 cycle adds one.
REQ-028 imem_ready while in VALID SHALL be ignored.

Reset
REQ-029 rst=1 SHALL asynchronously force: state FETCH, pc=RESET_PC, inst=NOP_INST, misalign_err=0.
REQ-030 During rst=1 imem_req SHALL be 0 and inst_valid 0; first cycle after release SHALL issue imem_req=1, imem_addr=RESET_PC.
REQ-031 Reset mid-fetch SHALL abandon the outstanding request; a late imem_ready during reset SHALL have no effect.

Structure
REQ-032 Shared package riscv_pkg SHALL hold RESET_PC default, NOP_INST constant, and FSM state encoding.
REQ-033 Block SHALL be flat; no sub-module.

Verification
REQ-034 Reset release, imem_ready=1 immediately, rdata=32'h0050_0093 -> imem_addr=0 cycle 1, inst_valid=1 cycle 2 with inst=32'h0050_0093, pc=0, pc_plus4=4.
REQ-035 Sequential retire, PCSel=0, stall_in=0 -> fetch addresses 0,4,8,C, one instruction per 2 cycles.
REQ-036 Branch: VALID at pc=8, PCSel=1, alu_out=32'h0000_0100 -> next imem_addr=32'h100; alu_out=32'h0000_0102 -> imem_addr=32'h100 and misalign_err pulses one cycle.
REQ-037 imem_ready low 3 cycles -> imem_req/imem_addr held stable 4 cycles; stall_in=1 for 5 cycles in VALID -> inst, pc frozen, no new request.
REQ-038 rst asserted mid-FETCH at pc=32'h40 with imem_ready=1 same cycle -> pc=0, inst=NOP_INST, inst_valid=0 immediately; refetch from 0 after release.
